// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core-bus to Avalon-MM bridge.
package core_bus_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned PTR_W     = 30;
  localparam int unsigned BYTE_EN_W = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } bus_state_t;

  localparam word_t BUS_TIMEOUT_DATA = 32'hDEADBEEF;
  localparam logic [BYTE_EN_W-1:0] BUS_FULL_BE = '1;

  // Word address to byte address: the core only ever moves whole 32-bit words.
  function automatic word_t ptr_to_byte_addr(input ptr_t ptr);
    return {ptr, 2'b00};
  endfunction

endpackage

// File: rtl/core_avalon_master_if.sv
// Core-bus request/response and Avalon-MM master signals in one bundle.
interface core_avalon_master_if import core_bus_pkg::*; ();

  ptr_t                  core_addr;
  logic                  core_write;
  word_t                 core_data_wr;
  logic                  core_start;
  logic                  core_ready;
  word_t                 core_data_rd;
  logic                  core_fault;

  word_t                 avl_address;
  logic                  avl_read;
  logic                  avl_write;
  word_t                 avl_writedata;
  logic [BYTE_EN_W-1:0]  avl_byteenable;
  word_t                 avl_readdata;
  logic                  avl_waitrequest;

  // Bridge view: answers the core, drives the Avalon port.
  modport master (
    input  core_addr, core_write, core_data_wr, core_start,
    output core_ready, core_data_rd, core_fault,
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_readdata, avl_waitrequest
  );

  // Environment view: core initiator plus Avalon slave/interconnect.
  modport slave (
    output core_addr, core_write, core_data_wr, core_start,
    input  core_ready, core_data_rd, core_fault,
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_readdata, avl_waitrequest
  );

endinterface

// File: rtl/core_avalon_master.sv
// Single-outstanding core-bus responder driving an Avalon-MM master port.
// Optional waitrequest timeout abort enabled by defining CORE_BUS_TIMEOUT_EN.
module core_avalon_master
  import core_bus_pkg::*;
`ifdef CORE_BUS_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
  )
`endif
  (
    input logic                  clk,
    input logic                  rst,
    core_avalon_master_if.master bus
  );

  bus_state_t state;
  logic       req_is_write;

  assign bus.avl_byteenable = BUS_FULL_BE;

`ifdef CORE_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             fault_q;

  assign bus.core_fault = fault_q;
`else
  assign bus.core_fault = 1'b0;
`endif

  // Request FSM; every bus-facing output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      req_is_write      <= 1'b0;
      bus.core_ready    <= 1'b0;
      bus.core_data_rd  <= '0;
      bus.avl_address   <= '0;
      bus.avl_read      <= 1'b0;
      bus.avl_write     <= 1'b0;
      bus.avl_writedata <= '0;
`ifdef CORE_BUS_TIMEOUT_EN
      tmo_cnt           <= '0;
      fault_q           <= 1'b0;
`endif
    end else begin
      bus.core_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.core_start) begin
            state             <= REQ;
            req_is_write      <= bus.core_write;
            bus.avl_address   <= ptr_to_byte_addr(bus.core_addr);
            bus.avl_writedata <= bus.core_data_wr;
            bus.avl_read      <= ~bus.core_write;
            bus.avl_write     <= bus.core_write;
`ifdef CORE_BUS_TIMEOUT_EN
            tmo_cnt           <= '0;
`endif
          end
        end
        REQ: begin
          // Starts arriving here are dropped: only one transaction in flight.
          if (!bus.avl_waitrequest) begin
            state          <= IDLE;
            bus.avl_read   <= 1'b0;
            bus.avl_write  <= 1'b0;
            bus.core_ready <= 1'b1;
            if (!req_is_write) begin
              bus.core_data_rd <= bus.avl_readdata;
            end
          end
`ifdef CORE_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Last tolerated stall: abandon the request and flag it.
            state          <= IDLE;
            bus.avl_read   <= 1'b0;
            bus.avl_write  <= 1'b0;
            bus.core_ready <= 1'b1;
            fault_q        <= 1'b1;
            if (!req_is_write) begin
              bus.core_data_rd <= BUS_TIMEOUT_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_avalon_master.sv
// Directed bench for core_avalon_master with a transaction-level reference model.
module tb_core_avalon_master;

`ifdef CORE_BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 0;
`endif

  logic clk;
  logic rst;

  core_avalon_master_if bus ();

`ifdef CORE_BUS_TIMEOUT_EN
  core_avalon_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );
`else
  core_avalon_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction, seen as a record plus a stall count.
  bit          pending   = 1'b0;
  bit          m_is_wr   = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [31:0] m_rd      = '0;
  bit          m_ready   = 1'b0;
  bit          m_fault   = 1'b0;
  int          m_stall   = 0;

  always @(posedge clk) begin
    m_ready = 1'b0;
    if (rst) begin
      pending = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rd    = '0;
      m_fault = 1'b0;
    end else if (!pending) begin
      if (bus.core_start) begin
        pending = 1'b1;
        m_is_wr = bus.core_write;
        m_addr  = bus.core_addr * 4;
        m_wdata = bus.core_data_wr;
        m_stall = 0;
      end
    end else if (!bus.avl_waitrequest) begin
      pending = 1'b0;
      m_ready = 1'b1;
      if (!m_is_wr) m_rd = bus.avl_readdata;
    end else begin
      m_stall++;
      if (TMO != 0 && m_stall == TMO) begin
        pending = 1'b0;
        m_ready = 1'b1;
        m_fault = 1'b1;
        if (!m_is_wr) m_rd = 32'hDEADBEEF;
      end
    end
  end

  // Per-cycle compare plus a few observation counters for the directed checks.
  int ready_q[$];
  int read_hi_cnt  = 0;
  int write_hi_cnt = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("core_ready",     32'(bus.core_ready),     32'(m_ready));
      chk("avl_read",       32'(bus.avl_read),       32'(pending && !m_is_wr));
      chk("avl_write",      32'(bus.avl_write),      32'(pending && m_is_wr));
      chk("avl_byteenable", 32'(bus.avl_byteenable), 32'h0000000F);
      chk("core_fault",     32'(bus.core_fault),     32'(m_fault));
      chk("core_data_rd",   bus.core_data_rd,        m_rd);
      if (pending) begin
        chk("avl_address",   bus.avl_address,   m_addr);
        chk("avl_writedata", bus.avl_writedata, m_wdata);
      end
      if (bus.core_ready === 1'b1) ready_q.push_back(cyc);
      if (bus.avl_read === 1'b1) read_hi_cnt++;
      if (bus.avl_write === 1'b1) write_hi_cnt++;
    end
  end

  task automatic do_start(input logic wr, input logic [29:0] addr, input logic [31:0] data,
                          output int sc);
    @(posedge clk);
    #1;
    bus.core_start   = 1'b1;
    bus.core_write   = wr;
    bus.core_addr    = addr;
    bus.core_data_wr = data;
    sc = cyc;
    @(posedge clk);
    #1;
    bus.core_start = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.core_ready === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int sc;
    int sc2;
    int rc;

    rst                 = 1'b1;
    bus.core_start      = 1'b0;
    bus.core_write      = 1'b0;
    bus.core_addr       = '0;
    bus.core_data_wr    = '0;
    bus.avl_readdata    = '0;
    bus.avl_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready",   32'(bus.core_ready), 32'h0);
    chk("rst_read",    32'(bus.avl_read),   32'h0);
    chk("rst_address", bus.avl_address,     32'h0);
    chk("rst_data_rd", bus.core_data_rd,    32'h0);

    // Read with no stall
    bus.avl_readdata = 32'hCAFE0001;
    read_hi_cnt = 0;
    do_start(1'b0, 30'h10, 32'h0, sc);
    @(negedge clk);
    chk("rd_address", bus.avl_address,   32'h00000040);
    chk("rd_read_hi", 32'(bus.avl_read), 32'h1);
    wait_ready(10, rc);
    chk("rd_latency", 32'(rc - sc),      32'd2);
    chk("rd_data",    bus.core_data_rd,  32'hCAFE0001);
    chk("rd_model",   m_rd,              32'hCAFE0001);
    chk("rd_hi_cyc",  32'(read_hi_cnt),  32'd1);

    // Write with three stall cycles
    bus.avl_waitrequest = 1'b1;
    write_hi_cnt = 0;
    do_start(1'b1, 30'h3, 32'h000000A5, sc);
    @(negedge clk);
    chk("wr_write_hi",  32'(bus.avl_write), 32'h1);
    chk("wr_writedata", bus.avl_writedata,  32'h000000A5);
    chk("wr_address",   bus.avl_address,    32'h0000000C);
    repeat (3) @(posedge clk);
    #1;
    bus.avl_waitrequest = 1'b0;
    wait_ready(10, rc);
    chk("wr_latency",  32'(rc - sc),       32'd5);
    chk("wr_hi_cyc",   32'(write_hi_cnt),  32'd4);
    chk("wr_data_rd",  bus.core_data_rd,   32'hCAFE0001);

    // Back-to-back: second start in the ready cycle of the first
    @(posedge clk);
    ready_q.delete();
    bus.avl_readdata = 32'h11112222;
    do_start(1'b0, 30'h20, 32'h0, sc);
    do_start(1'b1, 30'h21, 32'h00000055, sc2);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_pulses", 32'(ready_q.size()), 32'd2);
    if (ready_q.size() == 2) begin
      chk("b2b_ready0", 32'(ready_q[0] - sc), 32'd2);
      chk("b2b_ready1", 32'(ready_q[1] - sc), 32'd4);
    end
    chk("b2b_data_rd", bus.core_data_rd, 32'h11112222);

    // Start pulsed while a request is stalled is ignored
    ready_q.delete();
    bus.avl_readdata    = 32'h0BADF00D;
    bus.avl_waitrequest = 1'b1;
    do_start(1'b0, 30'h30, 32'h0, sc);
    bus.core_start   = 1'b1;
    bus.core_write   = 1'b1;
    bus.core_addr    = 30'h7;
    bus.core_data_wr = 32'h77777777;
    @(posedge clk);
    #1;
    bus.core_start = 1'b0;
    @(negedge clk);
    chk("ign_address", bus.avl_address,    32'h000000C0);
    chk("ign_write",   32'(bus.avl_write), 32'h0);
    @(posedge clk);
    #1;
    bus.avl_waitrequest = 1'b0;
    wait_ready(10, rc);
    chk("ign_latency", 32'(rc - sc), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_pulses",  32'(ready_q.size()), 32'd1);
    chk("ign_data_rd", bus.core_data_rd,    32'h0BADF00D);

    // Reset during a stalled read
    ready_q.delete();
    bus.avl_waitrequest = 1'b1;
    do_start(1'b0, 30'h44, 32'h0, sc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.avl_waitrequest = 1'b0;
    @(negedge clk);
    chk("rstmid_read",    32'(bus.avl_read), 32'h0);
    chk("rstmid_data_rd", bus.core_data_rd,  32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_no_ready", 32'(ready_q.size()), 32'd0);

    // Following read at the top word address
    bus.avl_readdata = 32'h12345678;
    do_start(1'b0, 30'h3FFFFFFF, 32'h0, sc);
    @(negedge clk);
    chk("top_address", bus.avl_address, 32'hFFFFFFFC);
    wait_ready(10, rc);
    chk("top_latency", 32'(rc - sc),      32'd2);
    chk("top_data_rd", bus.core_data_rd,  32'h12345678);

`ifdef CORE_BUS_TIMEOUT_EN
    // Waitrequest stuck high: abort after TMO stall cycles
    ready_q.delete();
    bus.avl_waitrequest = 1'b1;
    bus.avl_readdata    = 32'h99999999;
    do_start(1'b0, 30'h8, 32'h0, sc);
    wait_ready(40, rc);
    chk("tmo_latency", 32'(rc - sc),       32'(TMO + 1));
    chk("tmo_data_rd", bus.core_data_rd,   32'hDEADBEEF);
    chk("tmo_fault",   32'(bus.core_fault), 32'h1);
    @(posedge clk);
    #1;
    bus.avl_waitrequest = 1'b0;
    do_start(1'b1, 30'h9, 32'h1, sc);
    wait_ready(10, rc);
    chk("tmo_sticky",  32'(bus.core_fault), 32'h1);
    chk("tmo_pulses",  32'(ready_q.size()), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tmo_fault_clr", 32'(bus.core_fault), 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
